data_mem_uart: RTL and testbench
================================

Name: data_mem_uart

Overview:
- Data-side memory stage directly downstream of the single-cycle CPU core.
- Consumes the core's MemWrite, Mem_WrAddr, Mem_WrData and store funct3, and returns ReadData in the same cycle.
- Provides word-addressed data RAM with byte/half/word stores, plus a memory-mapped 8N1 UART transmitter. Firmware uses the UART to print results.

Parameters:
- MEM_WORDS, 64, number of 32-bit RAM words; power of two, at most 256.
- CLKS_PER_BIT, 434, clock cycles per UART bit; must be 2 or more.
- UART_BASE, 32'h0000_0400, base address of the UART register pair.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset: 0 = reset, sampled on the rising edge of clk.
- MemWrite  input  1  store strobe from the core.
- Mem_WrAddr  input  32  byte address for loads and stores.
- Mem_WrData  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- funct3  input  3  store size: 000 = SB, 001 = SH, 010 = SW; any other value is treated as SW.
- ReadData  output  32  combinational read data, always a full aligned word.
- uart_tx  output  1  serial line; idles high.
- tx_busy  output  1  high while a UART frame is in progress.

Behaviour:
- Address decode:
  - RAM when Mem_WrAddr < MEM_WORDS*4. Word index = Mem_WrAddr[log2(MEM_WORDS)+1:2].
  - TXDATA at UART_BASE (write-only; reads return 0).
  - STATUS at UART_BASE+4 (read-only): {31'b0, tx_busy}.
  - All other addresses: reads return 32'h0; writes are ignored.
- Reads: purely combinational from the address, with zero-cycle latency. A read in the same cycle as a store to the same word returns the old data. Load sign/zero extension is done by the core, not here.
- RAM stores take effect on the rising edge when MemWrite=1:
  - SB writes byte lane Mem_WrAddr[1:0] with Mem_WrData[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with Mem_WrData[15:0]; addr[0] is ignored.
  - SW writes all four lanes; addr[1:0] are ignored.
- Little-endian: lane 0 = bits [7:0].
- RAM contents are not cleared by reset. Simulation initial contents are X/zero; the bench must not rely on them.
- UART FSM states: IDLE, START, DATA, STOP.
  - Baud counter bcnt counts 0..CLKS_PER_BIT-1. Bit index bidx counts 0..7.
  - IDLE: uart_tx=1. A store of any size to TXDATA latches Mem_WrData[7:0] into the shift register, clears bcnt, and moves to START on that edge.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA with bidx=0.
  - DATA: uart_tx = shreg[bidx] (LSB first). Each bit is held CLKS_PER_BIT cycles. After bit 7, move to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then IDLE.
- uart_tx is a registered output; no combinational path from inputs.
- tx_busy = (state != IDLE). It rises on the edge that accepts the write and falls on the edge that returns to IDLE.
- Frame duration is exactly 10*CLKS_PER_BIT cycles. uart_tx goes low on the accepting edge.
- TXDATA write while tx_busy=1: ignored. The in-flight frame and shift register are unchanged, with no queueing.
- A TXDATA write in the same cycle STOP completes is ignored; firmware must poll STATUS until 0.
- Reset (reset=0 at a rising edge):
  - state=IDLE, uart_tx=1, tx_busy=0, bcnt=0, bidx=0, shreg=0.
  - A store in a reset cycle is ignored for both RAM and UART.
  - Reset mid-frame aborts the frame; uart_tx is high from the next edge.

Test Plan (CLKS_PER_BIT=4, MEM_WORDS=64):
1. SW 32'hDEADBEEF to 0x10, then read 0x10 → ReadData=32'hDEADBEEF. Read 0x100 → 32'h0.
2. SW 0 to 0x20; SB 8'hAA to 0x23; SH 16'h1234 to 0x20 → ReadData@0x20 = 32'hAA00_1234. SH to 0x21 behaves identically to SH to 0x20.
3. SW 32'h0000_00A5 to UART_BASE → tx_busy=1 on the next cycle. uart_tx sequence, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1. tx_busy=0 exactly 40 cycles after the write edge. STATUS read tracks tx_busy.
4. Write 8'h55 to TXDATA, then 8'hFF ten cycles later → frame carries 8'h55 only, and no second frame starts.
5. Start a frame, assert reset=0 for one edge at cycle 15 → uart_tx=1 and tx_busy=0 from that edge. A store presented during the reset cycle leaves RAM unchanged.
6. funct3=3'b111 store of 32'h01020304 to 0x30 → full word written, ReadData@0x30=32'h01020304.

Source files
------------

// File: rtl/data_mem_uart_if.sv
// Core-to-data-memory bus: store strobe, byte address, store data/size, and the
// combinational read data returned in the same cycle.
interface data_mem_uart_if;
    logic        MemWrite;
    logic [31:0] Mem_WrAddr;
    logic [31:0] Mem_WrData;
    logic [2:0]  funct3;
    logic [31:0] ReadData;

    modport master (
        output MemWrite, Mem_WrAddr, Mem_WrData, funct3,
        input  ReadData
    );

    modport slave (
        input  MemWrite, Mem_WrAddr, Mem_WrData, funct3,
        output ReadData
    );
endinterface

// File: rtl/data_mem_uart.sv
// Data memory stage: word RAM with byte/half/word stores plus a memory-mapped
// 8N1 UART transmitter (TXDATA write-only, STATUS read-only).
module data_mem_uart #(
    parameter int          MEM_WORDS    = 64,
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [31:0] UART_BASE    = 32'h0000_0400
) (
    input  logic            clk,
    input  logic            reset,
    data_mem_uart_if.slave  bus,
    output logic            uart_tx,
    output logic            tx_busy
);
    localparam int              AW          = $clog2(MEM_WORDS);
    localparam int              CW          = $clog2(CLKS_PER_BIT);
    localparam logic [31:0]     RAM_BYTES   = 32'(MEM_WORDS * 4);
    localparam logic [31:0]     STATUS_ADDR = UART_BASE + 32'd4;
    localparam logic [CW-1:0]   BCNT_LAST   = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

    logic [31:0]   mem_r [MEM_WORDS];
    logic          is_ram_s, is_tx_s, is_status_s;
    logic [AW-1:0] widx_s;
    logic [3:0]    be_s;
    logic [31:0]   wdata_s;

    tx_state_e     state_r, state_nxt_s;
    logic [CW-1:0] bcnt_r, bcnt_nxt_s;
    logic [2:0]    bidx_r, bidx_nxt_s;
    logic [7:0]    shreg_r, shreg_nxt_s;
    logic          bcnt_done_s, tx_nxt_s;
    logic          uart_tx_r, tx_busy_r;

    assign uart_tx = uart_tx_r;
    assign tx_busy = tx_busy_r;

    // Address decode, store lane enables and lane-replicated store data
    always_comb begin
        is_ram_s    = (bus.Mem_WrAddr < RAM_BYTES);
        is_tx_s     = (bus.Mem_WrAddr == UART_BASE);
        is_status_s = (bus.Mem_WrAddr == STATUS_ADDR);
        widx_s      = bus.Mem_WrAddr[AW+1:2];
        be_s        = 4'b1111;
        wdata_s     = bus.Mem_WrData;
        case (bus.funct3)
            3'b000: begin
                be_s    = 4'b0001 << bus.Mem_WrAddr[1:0];
                wdata_s = {4{bus.Mem_WrData[7:0]}};
            end
            3'b001: begin
                be_s    = bus.Mem_WrAddr[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{bus.Mem_WrData[15:0]}};
            end
            default: begin
                be_s    = 4'b1111;
                wdata_s = bus.Mem_WrData;
            end
        endcase
    end

    // Zero-latency read mux; a same-cycle store is not yet visible
    always_comb begin
        bus.ReadData = 32'h0000_0000;
        if (is_ram_s) begin
            bus.ReadData = mem_r[widx_s];
        end else if (is_status_s) begin
            bus.ReadData = {31'd0, tx_busy_r};
        end else begin
            bus.ReadData = 32'h0000_0000;
        end
    end

    // RAM byte-lane writes; contents survive reset
    always_ff @(posedge clk) begin
        if (reset && bus.MemWrite && is_ram_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[widx_s][8*i +: 8] <= wdata_s[8*i +: 8];
                end
            end
        end
    end

    // UART next-state: TXDATA writes are accepted only from IDLE
    always_comb begin
        state_nxt_s = state_r;
        bcnt_nxt_s  = bcnt_r;
        bidx_nxt_s  = bidx_r;
        shreg_nxt_s = shreg_r;
        bcnt_done_s = (bcnt_r == BCNT_LAST);
        case (state_r)
            IDLE: begin
                if (bus.MemWrite && is_tx_s) begin
                    state_nxt_s = START;
                    bcnt_nxt_s  = '0;
                    shreg_nxt_s = bus.Mem_WrData[7:0];
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (bcnt_done_s) begin
                    state_nxt_s = DATA;
                    bcnt_nxt_s  = '0;
                    bidx_nxt_s  = 3'd0;
                end else begin
                    bcnt_nxt_s  = bcnt_r + CW'(1);
                end
            end
            DATA: begin
                if (bcnt_done_s) begin
                    bcnt_nxt_s = '0;
                    if (bidx_r == 3'd7) begin
                        state_nxt_s = STOP;
                    end else begin
                        bidx_nxt_s  = bidx_r + 3'd1;
                    end
                end else begin
                    bcnt_nxt_s = bcnt_r + CW'(1);
                end
            end
            STOP: begin
                if (bcnt_done_s) begin
                    state_nxt_s = IDLE;
                    bcnt_nxt_s  = '0;
                end else begin
                    bcnt_nxt_s  = bcnt_r + CW'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                bcnt_nxt_s  = '0;
            end
        endcase

        // Line level is derived from the next state so uart_tx can be a flop
        case (state_nxt_s)
            IDLE:    tx_nxt_s = 1'b1;
            START:   tx_nxt_s = 1'b0;
            DATA:    tx_nxt_s = shreg_nxt_s[bidx_nxt_s];
            STOP:    tx_nxt_s = 1'b1;
            default: tx_nxt_s = 1'b1;
        endcase
    end

    // UART state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            bcnt_r    <= '0;
            bidx_r    <= 3'd0;
            shreg_r   <= 8'h00;
            uart_tx_r <= 1'b1;
            tx_busy_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            bcnt_r    <= bcnt_nxt_s;
            bidx_r    <= bidx_nxt_s;
            shreg_r   <= shreg_nxt_s;
            uart_tx_r <= tx_nxt_s;
            tx_busy_r <= (state_nxt_s != IDLE);
        end
    end
endmodule

// File: tb/tb_data_mem_uart.sv
// Self-checking bench for data_mem_uart: RAM stores checked against a byte-level
// array model, UART frames checked against the 8N1 bit timing computed per cycle.
module tb_data_mem_uart;
    localparam int          CPB  = 4;
    localparam logic [31:0] UART = 32'h0000_0400;

    logic clk;
    logic reset;
    logic uart_tx;
    logic tx_busy;
    int   n_cmp;
    int   n_fail;

    logic [31:0] ref_mem [64];

    data_mem_uart_if bus();

    data_mem_uart #(
        .MEM_WORDS   (64),
        .CLKS_PER_BIT(CPB),
        .UART_BASE   (UART)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .uart_tx(uart_tx),
        .tx_busy(tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void apply_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        int w;
        int lane;
        if (a >= 32'd256) return;
        w = int'(a[7:2]);
        case (f)
            3'b000: begin
                lane = int'(a[1:0]);
                ref_mem[w][lane*8 +: 8] = d[7:0];
            end
            3'b001: begin
                lane = a[1] ? 2 : 0;
                ref_mem[w][lane*8 +: 16] = d[15:0];
            end
            default: ref_mem[w] = d;
        endcase
    endfunction

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        @(negedge clk);
        bus.MemWrite   = 1'b1;
        bus.Mem_WrAddr = a;
        bus.Mem_WrData = d;
        bus.funct3     = f;
        @(posedge clk);
        #1;
        bus.MemWrite = 1'b0;
        apply_store(a, d, f);
    endtask

    task automatic read_word(input logic [31:0] a, output logic [31:0] v);
        @(negedge clk);
        bus.MemWrite   = 1'b0;
        bus.Mem_WrAddr = a;
        #1;
        v = bus.ReadData;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b0;
        bus.MemWrite = 1'b0;
        bus.Mem_WrAddr = 32'h0;
        bus.Mem_WrData = 32'h0;
        bus.funct3 = 3'b010;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({tx_busy, uart_tx} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_outputs: busy,tx=%b expected 01", {tx_busy, uart_tx});
        end
        reset = 1'b1;
        read_word(UART + 32'd4, v);
        n_cmp++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_status: got %h expected 00000000", v);
        end
    endtask

    task automatic test_ram_basic();
        logic [31:0] v;
        do_store(32'h10, 32'hDEADBEEF, 3'b010);
        read_word(32'h10, v);
        n_cmp++;
        if (v !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL sw_read: got %h expected deadbeef", v);
        end
        do_store(32'h100, 32'h1234_5678, 3'b010);
        read_word(32'h100, v);
        n_cmp++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL unmapped_read: got %h expected 00000000", v);
        end
        read_word(UART, v);
        n_cmp++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL txdata_read: got %h expected 00000000", v);
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] v;
        logic [31:0] a_sh [2];
        a_sh[0] = 32'h20;
        a_sh[1] = 32'h21;
        for (int i = 0; i < 2; i++) begin
            do_store(32'h20, 32'h0, 3'b010);
            do_store(32'h23, 32'h5555_55AA, 3'b000);
            do_store(a_sh[i], 32'hFFFF_1234, 3'b001);
            read_word(32'h20, v);
            n_cmp++;
            if (v !== 32'hAA00_1234) begin
                n_fail++;
                $display("FAIL sb_sh_merge(addr %h): got %h expected aa001234", a_sh[i], v);
            end
        end
    endtask

    task automatic test_funct3_default();
        logic [31:0] v;
        do_store(32'h30, 32'h0102_0304, 3'b111);
        read_word(32'h30, v);
        n_cmp++;
        if (v !== 32'h0102_0304) begin
            n_fail++;
            $display("FAIL funct3_111_sw: got %h expected 01020304", v);
        end
    endtask

    // One frame: optional TXDATA write at cycle inj, optional reset at cycle rst
    task automatic run_frame(input string name, input logic [7:0] data, input logic [2:0] f,
                             input int inj, input logic [7:0] inj_data, input int rst);
        logic [31:0] v;
        logic        exp_tx;
        logic        aborted;
        aborted = 1'b0;
        do_store(UART, {$urandom} & 32'hFFFF_FF00 | {24'd0, data}, f);
        for (int k = 0; k < 10*CPB; k++) begin
            if (aborted)            exp_tx = 1'b1;
            else if (k < CPB)       exp_tx = 1'b0;
            else if (k < 9*CPB)     exp_tx = data[(k-CPB)/CPB];
            else                    exp_tx = 1'b1;
            n_cmp++;
            if ({tx_busy, uart_tx} !== {~aborted, exp_tx}) begin
                n_fail++;
                $display("FAIL %s cycle %0d: busy,tx=%b expected %b", name, k,
                         {tx_busy, uart_tx}, {~aborted, exp_tx});
            end
            if (k % 8 == 3) begin
                read_word(UART + 32'd4, v);
                n_cmp++;
                if (v !== {31'd0, ~aborted}) begin
                    n_fail++;
                    $display("FAIL %s status cycle %0d: got %h expected %h", name, k, v, {31'd0, ~aborted});
                end
            end
            if (k == inj) begin
                @(negedge clk);
                bus.MemWrite = 1'b1;
                bus.Mem_WrAddr = UART;
                bus.Mem_WrData = {24'd0, inj_data};
                bus.funct3 = 3'b000;
                @(posedge clk);
                #1;
                bus.MemWrite = 1'b0;
            end else if (k == rst) begin
                @(negedge clk);
                reset = 1'b0;
                bus.MemWrite = 1'b1;
                bus.Mem_WrAddr = 32'h10;
                bus.Mem_WrData = ~ref_mem[4];
                bus.funct3 = 3'b010;
                @(posedge clk);
                #1;
                reset = 1'b1;
                bus.MemWrite = 1'b0;
                aborted = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if ({tx_busy, uart_tx} !== 2'b01) begin
                n_fail++;
                $display("FAIL %s idle after frame +%0d: busy,tx=%b expected 01", name, k, {tx_busy, uart_tx});
            end
            @(posedge clk);
            #1;
        end
        if (rst >= 0) begin
            read_word(32'h10, v);
            n_cmp++;
            if (v !== ref_mem[4]) begin
                n_fail++;
                $display("FAIL %s ram_after_reset_store: got %h expected %h", name, v, ref_mem[4]);
            end
        end
    endtask

    task automatic test_random_ram();
        logic [31:0] a, d, v;
        logic [2:0]  f;
        int          w;
        for (int i = 0; i < 64; i++) do_store(32'(i*4), $urandom, 3'b010);
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 255)) : 32'($urandom_range(256, 1020));
            d = $urandom;
            f = 3'($urandom_range(0, 7));
            @(negedge clk);
            bus.MemWrite = 1'b1;
            bus.Mem_WrAddr = a;
            bus.Mem_WrData = d;
            bus.funct3 = f;
            #1;
            n_cmp++;
            if (bus.ReadData !== ((a < 32'd256) ? ref_mem[a[7:2]] : 32'h0)) begin
                n_fail++;
                $display("FAIL rand_same_cycle_read[%0d] addr %h: got %h expected old %h", i, a,
                         bus.ReadData, (a < 32'd256) ? ref_mem[a[7:2]] : 32'h0);
            end
            @(posedge clk);
            #1;
            bus.MemWrite = 1'b0;
            apply_store(a, d, f);
            w = $urandom_range(0, 63);
            read_word(32'(w*4 + $urandom_range(0, 3)), v);
            n_cmp++;
            if (v !== ref_mem[w]) begin
                n_fail++;
                $display("FAIL rand_read[%0d] word %0d: got %h expected %h", i, w, v, ref_mem[w]);
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_ram_basic();
        test_byte_half();
        test_funct3_default();
        run_frame("frame_a5", 8'hA5, 3'b010, -1, 8'h00, -1);
        run_frame("busy_ignore", 8'h55, 3'b000, 10, 8'hFF, -1);
        run_frame("reset_abort", 8'h3C, 3'b001, -1, 8'h00, 15);
        run_frame("frame_rand", 8'($urandom), 3'($urandom_range(0, 7)), -1, 8'h00, -1);
        test_random_ram();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
